// File: rtl/mm_modexp_sequencer_if.sv
// Control interface of the square-and-multiply sequencer: start/exponent in,
// multiplier handshake, progress and completion status out.
interface mm_modexp_sequencer_if #(
    parameter int EXP_WIDTH = 256,
    parameter int CNT_WIDTH = $clog2(2*EXP_WIDTH+2),
    parameter int IDX_WIDTH = $clog2(EXP_WIDTH)
);
    logic                 start_i;
    logic [EXP_WIDTH-1:0] exp_i;
    logic                 mm_done_i;
    logic                 mm_start_o;
    logic [1:0]           mm_op_o;
    logic [IDX_WIDTH-1:0] bit_idx_o;
    logic [CNT_WIDTH-1:0] mm_count_o;
    logic                 busy_o;
    logic                 zero_exp_o;
    logic                 done_o;

    modport slave (
        input  start_i, exp_i, mm_done_i,
        output mm_start_o, mm_op_o, bit_idx_o, mm_count_o, busy_o, zero_exp_o, done_o
    );

    modport master (
        output start_i, exp_i, mm_done_i,
        input  mm_start_o, mm_op_o, bit_idx_o, mm_count_o, busy_o, zero_exp_o, done_o
    );
endinterface

// File: rtl/mm_modexp_sequencer.sv
// Left-to-right square-and-multiply scheduler for B^E mod p on top of a
// Montgomery multiplier; it only issues start pulses and operation codes.
module mm_modexp_sequencer #(
    parameter int EXP_WIDTH = 256,
    parameter int CNT_WIDTH = $clog2(2*EXP_WIDTH+2),
    parameter int IDX_WIDTH = $clog2(EXP_WIDTH)
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    mm_modexp_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_CONV_IN  = 2'b00;
    localparam logic [1:0] OP_SQR      = 2'b01;
    localparam logic [1:0] OP_MUL      = 2'b10;
    localparam logic [1:0] OP_CONV_OUT = 2'b11;

    localparam logic [IDX_WIDTH-1:0] IDX_TOP = IDX_WIDTH'(EXP_WIDTH-1);

    logic [2:0]           state_q,    state_d;
    logic [EXP_WIDTH-1:0] exp_q,      exp_d;
    logic [IDX_WIDTH-1:0] bit_idx_q,  bit_idx_d;
    logic [CNT_WIDTH-1:0] mm_count_q, mm_count_d;
    logic [1:0]           op_q,       op_d;
    logic                 zero_exp_q, zero_exp_d;

    logic cur_bit;
    logic idx_zero;

    assign cur_bit  = exp_q[bit_idx_q];
    assign idx_zero = (bit_idx_q == '0);

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        bit_idx_d  = bit_idx_q;
        mm_count_d = mm_count_q;
        op_d       = op_q;
        zero_exp_d = zero_exp_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    exp_d      = bus.exp_i;
                    bit_idx_d  = IDX_TOP;
                    mm_count_d = '0;
                    zero_exp_d = 1'b0;
                    state_d    = S_SCAN;
                end
            end

            // Skip leading zeros; the first set bit starts the Montgomery conversion.
            S_SCAN: begin
                if (cur_bit) begin
                    op_d    = OP_CONV_IN;
                    state_d = S_ISSUE;
                end else if (idx_zero) begin
                    zero_exp_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - IDX_WIDTH'(1);
                end
            end

            S_ISSUE: begin
                mm_count_d = mm_count_q + CNT_WIDTH'(1);
                state_d    = S_WAIT;
            end

            // op_q stays untouched until the multiplier reports completion.
            S_WAIT: begin
                if (bus.mm_done_i) begin
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_CONV_IN, OP_MUL: begin
                            if (idx_zero) begin
                                op_d = OP_CONV_OUT;
                            end else begin
                                bit_idx_d = bit_idx_q - IDX_WIDTH'(1);
                                op_d      = OP_SQR;
                            end
                        end
                        OP_SQR: begin
                            if (cur_bit) begin
                                op_d = OP_MUL;
                            end else if (idx_zero) begin
                                op_d = OP_CONV_OUT;
                            end else begin
                                bit_idx_d = bit_idx_q - IDX_WIDTH'(1);
                                op_d      = OP_SQR;
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            exp_q      <= '0;
            bit_idx_q  <= IDX_TOP;
            mm_count_q <= '0;
            op_q       <= OP_CONV_IN;
            zero_exp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            bit_idx_q  <= bit_idx_d;
            mm_count_q <= mm_count_d;
            op_q       <= op_d;
            zero_exp_q <= zero_exp_d;
        end
    end

    // The index register idles at the top bit, but the port reads 0 while idle.
    assign bus.mm_start_o = (state_q == S_ISSUE);
    assign bus.mm_op_o    = op_q;
    assign bus.bit_idx_o  = (state_q != S_IDLE) ? bit_idx_q : '0;
    assign bus.mm_count_o = mm_count_q;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.zero_exp_o = zero_exp_q;
    assign bus.done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_mm_modexp_sequencer.sv
// Directed and randomised bench for mm_modexp_sequencer with a behavioural
// multiplier and an op-sequence scoreboard.
module tb_mm_modexp_sequencer;
    localparam int EW = 8;
    localparam int CW = $clog2(2*EW+2);
    localparam int IW = $clog2(EW);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_modexp_sequencer_if #(.EXP_WIDTH(EW), .CNT_WIDTH(CW), .IDX_WIDTH(IW)) bus ();

    mm_modexp_sequencer #(.EXP_WIDTH(EW), .CNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_ops[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference op list built straight from the exponent bits.
    function automatic void push_ops(input logic [EW-1:0] e);
        int msb = -1;
        for (int i = 0; i < EW; i++) if (e[i]) msb = i;
        if (msb < 0) return;
        exp_ops.push_back(2'b00);
        for (int i = msb - 1; i >= 0; i--) begin
            exp_ops.push_back(2'b01);
            if (e[i]) exp_ops.push_back(2'b10);
        end
        exp_ops.push_back(2'b11);
    endfunction

    task automatic run_exp(input logic [EW-1:0] e, input int lat_lo, input int lat_hi,
                           input bit disturb, input string name);
        int cyc, msb, done_at, last_done, last_start, issued, exp_cnt, exp_first;
        bit pending, finished;
        logic [1:0] cur_op, want;
        exp_ops.delete();
        push_ops(e);
        msb = -1;
        for (int i = 0; i < EW; i++) if (e[i]) msb = i;
        exp_first = 2 + (EW - 1 - msb);
        exp_cnt   = (e == 0) ? 0 : 2 + msb + ($countones(e) - 1);
        if (disturb) begin
            bus.mm_done_i = 1'b1;
            @(negedge clk);
            bus.mm_done_i = 1'b0;
        end
        bus.exp_i   = e;
        bus.start_i = 1'b1;
        cyc = 0; pending = 0; finished = 0; issued = 0;
        last_done = -1; last_start = -1; done_at = -1; cur_op = 2'b00;
        for (int t = 0; t < 4000 && !finished; t++) begin
            @(negedge clk);
            cyc++;
            bus.start_i   = 1'b0;
            bus.mm_done_i = 1'b0;
            if (cyc == 1) chk({name, " busy"}, 32'(bus.busy_o), 32'd1);
            if (disturb && cyc == 1) bus.mm_done_i = 1'b1;
            if (disturb && issued == 1 && pending && cyc == last_start + 1) begin
                bus.start_i = 1'b1;
                bus.exp_i   = 8'hFF;
            end
            if (pending && cyc == done_at) begin
                bus.mm_done_i = 1'b1;
                pending   = 0;
                last_done = cyc;
                chk({name, " op_hold"}, 32'(bus.mm_op_o), 32'(cur_op));
            end
            if (bus.mm_start_o) begin
                if (issued == 0) chk({name, " first_start"}, 32'(cyc), 32'(exp_first));
                else             chk({name, " spacing"}, 32'(cyc), 32'(last_done + 1));
                chk({name, " count_at_issue"}, 32'(bus.mm_count_o), 32'(issued));
                want = (exp_ops.size() > 0) ? exp_ops.pop_front() : 2'bxx;
                chk({name, " op"}, 32'(bus.mm_op_o), 32'(want));
                cur_op     = bus.mm_op_o;
                issued++;
                pending    = 1;
                last_start = cyc;
                done_at    = cyc + int'($urandom_range(lat_hi, lat_lo));
            end
            if (bus.done_o) begin
                finished = 1;
                if (e == 0) chk({name, " done_cycle"}, 32'(cyc), 32'(EW + 1));
                else        chk({name, " done_cycle"}, 32'(cyc), 32'(last_done + 1));
                chk({name, " mm_count"}, 32'(bus.mm_count_o), 32'(exp_cnt));
                chk({name, " zero_exp"}, 32'(bus.zero_exp_o), 32'(e == 0));
                chk({name, " ops_left"}, 32'(exp_ops.size()), 32'd0);
                if (disturb) bus.start_i = 1'b1;
            end
        end
        chk({name, " done_seen"}, 32'(finished), 32'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk({name, " done_pulse"}, 32'(bus.done_o), 32'd0);
        chk({name, " idle"}, 32'(bus.busy_o), 32'd0);
        chk({name, " zero_hold"}, 32'(bus.zero_exp_o), 32'(e == 0));
        $display("run %s: E=0x%02h ops=%0d count=%0d cycles=%0d", name, e, issued, bus.mm_count_o, cyc);
    endtask

    initial begin
        bit seen;
        bus.start_i   = 1'b0;
        bus.exp_i     = '0;
        bus.mm_done_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        chk("reset mm_start", 32'(bus.mm_start_o), 32'd0);
        chk("reset mm_count", 32'(bus.mm_count_o), 32'd0);
        chk("reset done", 32'(bus.done_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_exp(8'h0B, 5, 5, 1'b0, "e0b");
        run_exp(8'h00, 5, 5, 1'b0, "e00");
        run_exp(8'h01, 5, 5, 1'b0, "e01");
        run_exp(8'hFF, 5, 5, 1'b0, "eff");
        run_exp(8'h0B, 5, 5, 1'b1, "e0b_disturb");

        // Asynchronous reset in the middle of a multiplication.
        bus.exp_i   = 8'h0B;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.mm_start_o) seen = 1;
        end
        chk("rst pre_start", 32'(seen), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(bus.busy_o), 32'd0);
        chk("rst mm_start", 32'(bus.mm_start_o), 32'd0);
        chk("rst mm_op", 32'(bus.mm_op_o), 32'd0);
        chk("rst bit_idx", 32'(bus.bit_idx_o), 32'd0);
        chk("rst mm_count", 32'(bus.mm_count_o), 32'd0);
        chk("rst zero_exp", 32'(bus.zero_exp_o), 32'd0);
        chk("rst done", 32'(bus.done_o), 32'd0);
        $display("run reset: async reset mid-WAIT applied");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_exp(8'h02, 5, 5, 1'b0, "e02_after_rst");

        for (int r = 0; r < 150; r++) begin
            run_exp(EW'($urandom_range(255, 1)), 1, 40, 1'b0, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
